// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the TIMING-mode countdown/stopwatch core and its display driver.
package countdown_timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int UNITS_MAX = 9;
    localparam int TENS_MAX  = 5;

    localparam int CS_UNITS_LSB = 0;
    localparam int CS_TENS_LSB  = 4;
    localparam int S_UNITS_LSB  = 8;
    localparam int S_TENS_LSB   = 12;
    localparam int M_UNITS_LSB  = 15;
    localparam int M_TENS_LSB   = 19;

    localparam logic [2:0] MODE_TIMING = 3'b011;

    // A preset pair is {tens[2:0], units[3:0]}; tens may not exceed 5, units may not exceed 9.
    function automatic logic bcd_pair_ok(input logic [6:0] pair);
        return (pair[3:0] <= 4'(UNITS_MAX)) && (pair[6:4] <= 3'(TENS_MAX));
    endfunction

endpackage

// File: rtl/countdown_timer_bcd_digit.sv
// One BCD digit of the timer chain; wraps at MAX and reports carry/borrow to the next digit.
module countdown_timer_bcd_digit #(
    parameter int MAX = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    input  logic       dec,
    input  logic       clr,
    input  logic       ld,
    input  logic [3:0] ld_val,
    output logic [3:0] value,
    output logic       carry,
    output logic       borrow
);
    localparam logic [3:0] MAX4 = 4'(MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= 4'd0;
        end else if (clr) begin
            value <= 4'd0;
        end else if (ld) begin
            value <= ld_val;
        end else if (inc) begin
            value <= (value == MAX4) ? 4'd0 : value + 4'd1;
        end else if (dec) begin
            value <= (value == 4'd0) ? MAX4 : value - 4'd1;
        end
    end

    assign carry  = inc && (value == MAX4);
    assign borrow = dec && (value == 4'd0);

endmodule

// File: rtl/countdown_timer.sv
// Stopwatch / countdown core: run-pause FSM, tick prescaler, preset validation and a six-digit BCD chain.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 100
) (
    input  logic        clk_sys,
    input  logic        rstn,
    input  logic        en,
    input  logic        count_down,
    input  logic        btn_start,
    input  logic        btn_clear,
    input  logic        load,
    input  logic [6:0]  load_min_bcd,
    input  logic [6:0]  load_sec_bcd,
    output logic [19:0] time_data,
    output logic [1:0]  min_tens_hi,
    output logic        running,
    output logic        done,
    output logic        load_err
);
    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [3:0] U_MAX = 4'(UNITS_MAX);
    localparam logic [3:0] T_MAX = 4'(TENS_MAX);

    state_t           state, state_next;
    logic             mode_down;
    logic [CNT_W-1:0] cnt;
    logic             start, clear, ld;
    logic             tick, step;
    logic             upper_zero, upper_max, all_zero, all_max, pre_down, pre_up;
    logic             at_term, pre_term, preset_ok;
    logic             ld_ok, err_next, done_next, enter_run;
    logic [3:0]       dig    [6];
    logic [3:0]       preset [6];
    logic             unused_chain_end;

    assign start = en && btn_start;
    assign clear = en && btn_clear;
    assign ld    = en && load;

    assign preset[0] = 4'd0;
    assign preset[1] = 4'd0;
    assign preset[2] = load_sec_bcd[3:0];
    assign preset[3] = {1'b0, load_sec_bcd[6:4]};
    assign preset[4] = load_min_bcd[3:0];
    assign preset[5] = {1'b0, load_min_bcd[6:4]};
    assign preset_ok = bcd_pair_ok(load_min_bcd) && bcd_pair_ok(load_sec_bcd);

    assign upper_zero = (dig[1] == 4'd0) && (dig[2] == 4'd0) && (dig[3] == 4'd0)
                     && (dig[4] == 4'd0) && (dig[5] == 4'd0);
    assign upper_max  = (dig[1] == U_MAX) && (dig[2] == U_MAX) && (dig[3] == T_MAX)
                     && (dig[4] == U_MAX) && (dig[5] == T_MAX);
    assign all_zero = upper_zero && (dig[0] == 4'd0);
    assign pre_down = upper_zero && (dig[0] == 4'd1);
    assign all_max  = upper_max && (dig[0] == U_MAX);
    assign pre_up   = upper_max && (dig[0] == U_MAX - 4'd1);
    assign at_term  = mode_down ? all_zero : all_max;
    assign pre_term = mode_down ? pre_down : pre_up;

    // A tick arriving while already at the terminal value must not wrap the digits.
    assign tick = (state == RUN) && (cnt == CNT_LAST);
    assign step = tick && !at_term;

    for (genvar i = 0; i < 6; i++) begin : g_digit
        localparam int MAX = (i == 3 || i == 5) ? TENS_MAX : UNITS_MAX;
        logic inc, dec, carry, borrow;
        if (i == 0) begin : g_first
            assign inc = step && !mode_down;
            assign dec = step && mode_down;
        end else begin : g_rest
            assign inc = g_digit[i-1].carry;
            assign dec = g_digit[i-1].borrow;
        end
        countdown_timer_bcd_digit #(.MAX(MAX)) u_digit (
            .clk    (clk_sys),
            .rst_n  (rstn),
            .inc    (inc),
            .dec    (dec),
            .clr    (clear),
            .ld     (ld_ok),
            .ld_val (preset[i]),
            .value  (dig[i]),
            .carry  (carry),
            .borrow (borrow)
        );
    end

    assign unused_chain_end = g_digit[5].carry | g_digit[5].borrow;

    assign time_data   = {dig[5][0], dig[4], dig[3][2:0], dig[2], dig[1], dig[0]};
    assign min_tens_hi = dig[5][2:1];

    // Prescaler restarts on every entry into RUN so the first tick lands a full period later.
    always_ff @(posedge clk_sys or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            mode_down <= 1'b0;
            cnt       <= '0;
            running   <= 1'b0;
            done      <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && state_next == RUN) begin
                mode_down <= count_down;
            end
            if (enter_run) begin
                cnt <= '0;
            end else if (state == RUN) begin
                cnt <= tick ? '0 : cnt + 1'b1;
            end
            running  <= (state_next == RUN);
            done     <= done_next;
            load_err <= err_next;
        end
    end

    // Priority: clear, then start, then load, then the terminal check on a tick.
    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = IDLE;
        end else if (start) begin
            case (state)
                IDLE:    state_next = (count_down && all_zero) ? IDLE : RUN;
                RUN:     state_next = PAUSE;
                PAUSE:   state_next = RUN;
                default: state_next = state;
            endcase
        end else if (ld && state != RUN) begin
            if (preset_ok) begin
                state_next = IDLE;
            end
        end else if (tick && (pre_term || at_term)) begin
            state_next = DONE;
        end
    end

    always_comb begin
        ld_ok     = 1'b0;
        err_next  = 1'b0;
        done_next = 1'b0;
        enter_run = 1'b0;
        if (ld && !clear && !start && state != RUN) begin
            ld_ok    = preset_ok;
            err_next = !preset_ok;
        end
        done_next = (state == RUN) && (state_next == DONE);
        enter_run = (state != RUN) && (state_next == RUN);
    end

endmodule
